// File: rtl/axil_master_arbiter.sv
// -----------------------------------------------------------------------------
// axil_master_arbiter
//
// Shares one AXI-Lite master user interface between NUM_REQ requesters.
// The arbiter accepts one command at a time, issues it to the master as a
// single-cycle write_req/read_req, waits for the matching done pulse and
// returns a single-cycle response to the requester that was granted.
//
// Arbitration is round-robin by default: the search for the next grant
// starts at the requester after the one most recently granted. Defining
// AXIL_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins) and
// removes the rotating pointer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/_write  per-requester command valid / write(1) or read(0)
//   req_addr/_wdata/_wstrb
//                     packed per-requester fields, requester i in slice i
//   req_ready         one-hot accept, combinational, only in IDLE
//   rsp_valid         one-hot single-cycle completion pulse
//   rsp_write         type of the completing transaction
//   rsp_rdata         read data with rsp_valid (0 for writes)
//   busy              high whenever a transaction is in progress
//   m_write_*         write command to / completion from the master
//   m_read_*          read command to / data and completion from the master
// -----------------------------------------------------------------------------
module axil_master_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]             req_ready,

  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_write,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           busy,

  output logic                           m_write_req,
  output logic [ADDR_WIDTH-1:0]          m_write_addr,
  output logic [DATA_WIDTH-1:0]          m_write_data,
  output logic [DATA_WIDTH/8-1:0]        m_write_strb,
  input  logic                           m_write_done,

  output logic                           m_read_req,
  output logic [ADDR_WIDTH-1:0]          m_read_addr,
  input  logic [DATA_WIDTH-1:0]          m_read_data,
  input  logic                           m_read_done
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant;      // combinational winner for this IDLE cycle
  logic [IDX_W-1:0]   grant_q;    // requester owning the in-flight transaction
  logic               write_q;    // type of the in-flight transaction
  logic               any_valid;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;

`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr;        // highest-priority requester for the next grant
`endif

  // ---------------------------------------------------------------------------
  // Grant search. Round-robin walks NUM_REQ slots starting at ptr and wraps;
  // fixed priority walks from slot 0. The first valid slot found wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] slot;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    slot      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = k + 32'(ptr);
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
`endif
      slot = IDX_W'(idx);
      if (!any_valid && req_valid[slot]) begin
        any_valid = 1'b1;
        grant     = slot;
      end
    end
  end

  // Field mux for the winning requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Accept is offered only while idle. Reset masks it so that no requester
  // sees a handshake that the reset is about to discard.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid && !rst) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM with registered master and response outputs.
  // The master command registers are loaded on the accept edge, so the values
  // appear together with the req pulse in ISSUE and stay put until the next
  // command of the same type is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_q      <= '0;
      write_q      <= 1'b0;
      rsp_valid    <= '0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      m_write_req  <= 1'b0;
      m_write_addr <= '0;
      m_write_data <= '0;
      m_write_strb <= '0;
      m_read_req   <= 1'b0;
      m_read_addr  <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      ptr          <= '0;
`endif
    end else begin
      m_write_req <= 1'b0;
      m_read_req  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_q <= grant;
            write_q <= req_write[grant];
`ifndef AXIL_ARB_FIXED_PRIO_EN
            ptr     <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`endif
            if (req_write[grant]) begin
              m_write_req  <= 1'b1;
              m_write_addr <= sel_addr;
              m_write_data <= sel_wdata;
              m_write_strb <= sel_wstrb;
            end else begin
              m_read_req  <= 1'b1;
              m_read_addr <= sel_addr;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          // Only the done pulse matching the outstanding type completes it.
          if (write_q ? m_write_done : m_read_done) begin
            rsp_valid[grant_q] <= 1'b1;
            rsp_write          <= write_q;
            rsp_rdata          <= write_q ? '0 : m_read_data;
            state              <= RESP;
          end
        end

        RESP: begin
          rsp_valid <= '0;
          rsp_write <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_master_arbiter
//
// Directed bench for axil_master_arbiter (NUM_REQ=4, 32-bit address/data).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
// The master is played cycle by cycle by the scenario tasks.
// -----------------------------------------------------------------------------
module tb_axil_master_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_wstrb;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_write;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic              m_write_req;
  logic [AW-1:0]     m_write_addr;
  logic [DW-1:0]     m_write_data;
  logic [SW-1:0]     m_write_strb;
  logic              m_write_done;
  logic              m_read_req;
  logic [AW-1:0]     m_read_addr;
  logic [DW-1:0]     m_read_data;
  logic              m_read_done;

  int total;
  int bad;

  axil_master_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .m_write_req  (m_write_req),
    .m_write_addr (m_write_addr),
    .m_write_data (m_write_data),
    .m_write_strb (m_write_strb),
    .m_write_done (m_write_done),
    .m_read_req   (m_read_req),
    .m_read_addr  (m_read_addr),
    .m_read_data  (m_read_data),
    .m_read_done  (m_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
    req_wstrb[idx*SW +: SW] = s;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_wstrb    = '0;
    m_write_done = 1'b0;
    m_read_done  = 1'b0;
    m_read_data  = '0;
    tick();
    tick();
    req_valid = 4'b1111;
    settle();
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    total++;
    if ({busy, rsp_valid, rsp_write, m_write_req, m_read_req} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got busy=%b rsp_valid=%b rsp_write=%b wreq=%b rreq=%b expected all 0",
                      busy, rsp_valid, rsp_write, m_write_req, m_read_req);
    end
    total++;
    if ({m_write_addr, m_write_data, m_write_strb, m_read_addr, rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_data: got waddr=%h wdata=%h wstrb=%h raddr=%h rdata=%h expected all 0",
                      m_write_addr, m_write_data, m_write_strb, m_read_addr, rsp_rdata);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_write();
    set_req(1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    req_valid = 4'b0010;
    settle();
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL wr_ready: got %b expected 0010", req_ready);
    end
    tick();                                 // ISSUE
    req_valid = '0;
    settle();
    total++;
    if ({m_write_req, m_read_req, busy} !== 3'b101) begin
      bad++; $display("FAIL wr_issue_req: got wreq=%b rreq=%b busy=%b expected 1 0 1",
                      m_write_req, m_read_req, busy);
    end
    total++;
    if ({m_write_addr, m_write_data, m_write_strb} !== {32'h10, 32'hA5A5_A5A5, 4'hF}) begin
      bad++; $display("FAIL wr_issue_fields: got %h %h %h expected 00000010 a5a5a5a5 f",
                      m_write_addr, m_write_data, m_write_strb);
    end
    tick();                                 // WAIT
    settle();
    total++;
    if ({m_write_req, m_write_addr} !== {1'b0, 32'h10}) begin
      bad++; $display("FAIL wr_req_width: got wreq=%b addr=%h expected 0 00000010",
                      m_write_req, m_write_addr);
    end
    m_write_done = 1'b1;
    tick();                                 // RESP
    m_write_done = 1'b0;
    settle();
    total++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {4'b0010, 1'b1, 32'h0}) begin
      bad++; $display("FAIL wr_rsp: got valid=%b write=%b rdata=%h expected 0010 1 00000000",
                      rsp_valid, rsp_write, rsp_rdata);
    end
    tick();                                 // IDLE
    settle();
    total++;
    if ({rsp_valid, busy} !== 5'b0) begin
      bad++; $display("FAIL wr_rsp_end: got valid=%b busy=%b expected 0000 0", rsp_valid, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    logic wr_seen;
    wr_seen = 1'b0;
    set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid = 4'b0100;
    settle();
    wr_seen |= m_write_req;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL rd_ready: got %b expected 0100", req_ready);
    end
    tick();                                 // ISSUE
    req_valid = '0;
    settle();
    wr_seen |= m_write_req;
    total++;
    if ({m_read_req, m_read_addr} !== {1'b1, 32'h20}) begin
      bad++; $display("FAIL rd_issue: got rreq=%b addr=%h expected 1 00000020", m_read_req, m_read_addr);
    end
    tick();                                 // WAIT
    settle();
    wr_seen |= m_write_req;
    m_read_done = 1'b1;
    m_read_data = 32'hDEAD_BEEF;
    tick();                                 // RESP
    m_read_done = 1'b0;
    m_read_data = 32'h0;
    settle();
    wr_seen |= m_write_req;
    total++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {4'b0100, 1'b0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL rd_rsp: got valid=%b write=%b rdata=%h expected 0100 0 deadbeef",
                      rsp_valid, rsp_write, rsp_rdata);
    end
    tick();                                 // IDLE
    settle();
    wr_seen |= m_write_req;
    total++;
    if ({rsp_valid, rsp_rdata} !== {4'b0, 32'h0}) begin
      bad++; $display("FAIL rd_rsp_end: got valid=%b rdata=%h expected 0000 00000000", rsp_valid, rsp_rdata);
    end
    total++;
    if (wr_seen !== 1'b0) begin
      bad++; $display("FAIL rd_no_wreq: got %b expected 0", wr_seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [NR-1:0] exp_oh;
    int exp_idx;
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'(i * 256), 32'h0, 4'h0);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = n % 4;
`endif
      exp_oh = 4'(1 << exp_idx);
      settle();
      total++;
      if (req_ready !== exp_oh) begin
        bad++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, exp_oh);
      end
      tick();                               // ISSUE
      settle();
      total++;
      if ({m_read_req, m_read_addr} !== {1'b1, 32'(exp_idx * 256)}) begin
        bad++; $display("FAIL rr_addr%0d: got rreq=%b addr=%h expected 1 %h",
                        n, m_read_req, m_read_addr, 32'(exp_idx * 256));
      end
      tick();                               // WAIT
      m_read_done = 1'b1;
      m_read_data = 32'(32'hC0DE_0000 + n);
      tick();                               // RESP
      m_read_done = 1'b0;
      settle();
      total++;
      if ({rsp_valid, rsp_rdata} !== {exp_oh, 32'(32'hC0DE_0000 + n)}) begin
        bad++; $display("FAIL rr_rsp%0d: got valid=%b rdata=%h expected %b %h",
                        n, rsp_valid, rsp_rdata, exp_oh, 32'(32'hC0DE_0000 + n));
      end
      tick();                               // IDLE
    end
    req_valid = '0;
    m_read_data = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stray_done();
    pulse_reset();
    set_req(0, 1'b1, 32'h44, 32'h1122_3344, 4'h3);
    req_valid = 4'b0001;
    tick();                                 // ISSUE
    req_valid = '0;
    tick();                                 // WAIT
    m_read_done = 1'b1;
    m_read_data = 32'hFFFF_FFFF;
    tick();                                 // still WAIT
    m_read_done = 1'b0;
    m_read_data = 32'h0;
    settle();
    total++;
    if ({busy, rsp_valid} !== {1'b1, 4'b0000}) begin
      bad++; $display("FAIL stray_ignored: got busy=%b valid=%b expected 1 0000", busy, rsp_valid);
    end
    tick();
    settle();
    total++;
    if ({busy, rsp_valid} !== {1'b1, 4'b0000}) begin
      bad++; $display("FAIL stray_still_wait: got busy=%b valid=%b expected 1 0000", busy, rsp_valid);
    end
    m_write_done = 1'b1;
    tick();                                 // RESP
    m_write_done = 1'b0;
    settle();
    total++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {4'b0001, 1'b1, 32'h0}) begin
      bad++; $display("FAIL stray_wr_rsp: got valid=%b write=%b rdata=%h expected 0001 1 00000000",
                      rsp_valid, rsp_write, rsp_rdata);
    end
    tick();                                 // IDLE
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    set_req(2, 1'b0, 32'h30, 32'h0, 4'h0);
    req_valid = 4'b0100;
    tick();                                 // ISSUE
    req_valid = '0;
    tick();                                 // WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    total++;
    if ({busy, rsp_valid, rsp_write, m_read_req, m_write_req} !== 8'h00) begin
      bad++; $display("FAIL rstw_ctrl: got busy=%b valid=%b write=%b rreq=%b wreq=%b expected all 0",
                      busy, rsp_valid, rsp_write, m_read_req, m_write_req);
    end
    total++;
    if ({m_read_addr, m_write_addr, rsp_rdata} !== '0) begin
      bad++; $display("FAIL rstw_data: got raddr=%h waddr=%h rdata=%h expected all 0",
                      m_read_addr, m_write_addr, rsp_rdata);
    end
    m_read_done = 1'b1;
    m_read_data = 32'h5555_AAAA;
    tick();
    m_read_done = 1'b0;
    m_read_data = 32'h0;
    tick();
    settle();
    total++;
    if ({busy, rsp_valid} !== 5'b0) begin
      bad++; $display("FAIL rstw_no_rsp: got busy=%b valid=%b expected 0 0000", busy, rsp_valid);
    end
    set_req(1, 1'b0, 32'h14, 32'h0, 4'h0);
    set_req(3, 1'b0, 32'h34, 32'h0, 4'h0);
    req_valid = 4'b1010;
    settle();
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL rstw_ptr: got %b expected 0010", req_ready);
    end
    tick();                                 // ISSUE
    req_valid = '0;
    tick();                                 // WAIT
    m_read_done = 1'b1;
    tick();                                 // RESP
    m_read_done = 1'b0;
    tick();                                 // IDLE
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    set_req(3, 1'b1, 32'h3C, 32'hCAFE_F00D, 4'hC);
    req_valid = 4'b1000;
    settle();
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL b2b_first_ready: got %b expected 1000", req_ready);
    end
    tick();                                 // ISSUE, next command presented
    set_req(3, 1'b0, 32'h300, 32'h0, 4'h0);
    settle();
    total++;
    if ({req_ready, m_write_req, m_write_data} !== {4'b0000, 1'b1, 32'hCAFE_F00D}) begin
      bad++; $display("FAIL b2b_issue: got ready=%b wreq=%b wdata=%h expected 0000 1 cafef00d",
                      req_ready, m_write_req, m_write_data);
    end
    tick();                                 // WAIT
    m_write_done = 1'b1;
    tick();                                 // RESP
    m_write_done = 1'b0;
    settle();
    total++;
    if ({rsp_valid, req_ready} !== {4'b1000, 4'b0000}) begin
      bad++; $display("FAIL b2b_resp: got valid=%b ready=%b expected 1000 0000", rsp_valid, req_ready);
    end
    tick();                                 // IDLE
    settle();
    total++;
    if ({req_ready, busy} !== {4'b1000, 1'b0}) begin
      bad++; $display("FAIL b2b_second_ready: got ready=%b busy=%b expected 1000 0", req_ready, busy);
    end
    tick();                                 // ISSUE
    req_valid = '0;
    settle();
    total++;
    if ({m_read_req, m_read_addr, m_write_addr} !== {1'b1, 32'h300, 32'h3C}) begin
      bad++; $display("FAIL b2b_second_issue: got rreq=%b raddr=%h waddr=%h expected 1 00000300 0000003c",
                      m_read_req, m_read_addr, m_write_addr);
    end
    tick();                                 // WAIT
    m_read_done = 1'b1;
    m_read_data = 32'h1234_5678;
    tick();                                 // RESP
    m_read_done = 1'b0;
    m_read_data = 32'h0;
    settle();
    total++;
    if ({rsp_valid, rsp_write, rsp_rdata} !== {4'b1000, 1'b0, 32'h1234_5678}) begin
      bad++; $display("FAIL b2b_second_rsp: got valid=%b write=%b rdata=%h expected 1000 0 12345678",
                      rsp_valid, rsp_write, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_stray_done();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
